// File: rtl/stream_cmp_pkg.sv
// Shared types and helpers for the stream comparator: match modes, FSM
// states and the mode-to-match mapping applied to the raw compare flags.
package stream_cmp_pkg;

  typedef enum logic [1:0] {
    CMP_EQ = 2'b00,
    CMP_NE = 2'b01,
    CMP_LT = 2'b10,
    CMP_GT = 2'b11
  } cmp_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } cmp_state_t;

  // Reduce the three raw compare flags to a single match bit for the mode.
  function automatic logic mode_match(cmp_mode_t mode, logic eq, logic lt, logic gt);
    logic m;
    case (mode)
      CMP_EQ:  m = eq;
      CMP_NE:  m = ~eq;
      CMP_LT:  m = lt;
      default: m = gt;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/word_compare.sv
// Combinational unsigned magnitude compare of two WIDTH-bit words.
// Exactly one of eq/lt/gt is high for any input pair.
module word_compare #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  assign eq = (a == b);
  assign lt = (a < b);
  assign gt = (a > b);

endmodule

// File: rtl/stream_comparator.sv
// Streaming word-pair comparator. Consumes len pairs from two valid-gated
// streams, registers per-pair compare results, keeps a saturating mismatch
// count plus the index of the first mismatch, and pulses done with a pass
// verdict at the end of the run.
module stream_comparator #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [LEN_W-1:0] len,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             in_ready,
  output logic             res_valid,
  output logic             res_match,
  output logic             res_eq,
  output logic             res_lt,
  output logic             res_gt,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [LEN_W-1:0] first_mm_idx
);

  import stream_cmp_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  cmp_state_t       state_q, state_d;
  cmp_mode_t        mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] first_q, first_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic             rvld_q, rvld_d;
  logic             rmatch_q, rmatch_d;
  logic             req_q, req_d;
  logic             rlt_q, rlt_d;
  logic             rgt_q, rgt_d;

  logic             cmp_eq, cmp_lt, cmp_gt;
  logic             pair_match;
  logic             beat;
  logic             last_beat;

  word_compare #(.WIDTH(WIDTH)) u_cmp (
    .a  (a_data),
    .b  (b_data),
    .eq (cmp_eq),
    .lt (cmp_lt),
    .gt (cmp_gt)
  );

  assign pair_match = mode_match(mode_q, cmp_eq, cmp_lt, cmp_gt);
  assign beat       = a_valid & b_valid & in_ready;
  // idx counts accepted pairs, so the pair at idx == len-1 closes the run.
  assign last_beat  = beat && (idx_q == (len_q - LEN_W'(1)));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: a zero-length run skips RUN and finishes immediately.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (last_beat) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from the current state only.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_RUN:  begin in_ready = 1'b1; busy = 1'b1; end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next state: run setup on start, result capture and counting per beat.
  always_comb begin
    mode_d   = mode_q;
    len_d    = len_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    pass_d   = pass_q;
    rvld_d   = beat;
    rmatch_d = rmatch_q;
    req_d    = req_q;
    rlt_d    = rlt_q;
    rgt_d    = rgt_q;

    if ((state_q == ST_IDLE) && start) begin
      mode_d  = cmp_mode_t'(mode);
      len_d   = len;
      idx_d   = '0;
      cnt_d   = '0;
      first_d = '0;
      pass_d  = (len == '0);
    end

    if (beat) begin
      rmatch_d = pair_match;
      req_d    = cmp_eq;
      rlt_d    = cmp_lt;
      rgt_d    = cmp_gt;
      idx_d    = idx_q + LEN_W'(1);
      if (!pair_match) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        // The counter saturates rather than wraps, so zero means no mismatch yet.
        if (cnt_q == '0) first_d = idx_q;
      end
      // Verdict is registered with the last beat so it is visible alongside done.
      if (last_beat) pass_d = pair_match && (cnt_q == '0);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= CMP_EQ;
      len_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      first_q  <= '0;
      pass_q   <= 1'b0;
      rvld_q   <= 1'b0;
      rmatch_q <= 1'b0;
      req_q    <= 1'b0;
      rlt_q    <= 1'b0;
      rgt_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      pass_q   <= pass_d;
      rvld_q   <= rvld_d;
      rmatch_q <= rmatch_d;
      req_q    <= req_d;
      rlt_q    <= rlt_d;
      rgt_q    <= rgt_d;
    end
  end

  assign res_valid    = rvld_q;
  assign res_match    = rmatch_q;
  assign res_eq       = req_q;
  assign res_lt       = rlt_q;
  assign res_gt       = rgt_q;
  assign pass         = pass_q;
  assign mismatch_cnt = cnt_q;
  assign first_mm_idx = first_q;

endmodule

// File: tb/tb_stream_comparator.sv
// Scoreboard bench for stream_comparator: the driver pushes expected
// per-pair results from a plain-arithmetic reference model, a negedge
// monitor pops and compares on every res_valid.
module tb_stream_comparator;

  typedef struct {
    bit match;
    bit eq;
    bit lt;
    bit gt;
    int cnt;
    int first;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [8:0] len = 9'd0;
  logic       a_valid = 1'b0;
  logic [3:0] a_data = 4'd0;
  logic       b_valid = 1'b0;
  logic [3:0] b_data = 4'd0;

  logic       in_ready, res_valid, res_match, res_eq, res_lt, res_gt, busy, done, pass;
  logic [7:0] mismatch_cnt;
  logic [8:0] first_mm_idx;

  logic       s_in_ready, s_res_valid, s_res_match, s_res_eq, s_res_lt, s_res_gt;
  logic       s_busy, s_done, s_pass;
  logic [1:0] s_mismatch_cnt;
  logic [7:0] s_first_mm_idx;

  stream_comparator #(.WIDTH(4), .LEN_W(9), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .len(len),
    .a_valid(a_valid), .a_data(a_data), .b_valid(b_valid), .b_data(b_data),
    .in_ready(in_ready), .res_valid(res_valid), .res_match(res_match),
    .res_eq(res_eq), .res_lt(res_lt), .res_gt(res_gt), .busy(busy),
    .done(done), .pass(pass), .mismatch_cnt(mismatch_cnt), .first_mm_idx(first_mm_idx)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation.
  stream_comparator #(.WIDTH(4), .LEN_W(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .len(len[7:0]),
    .a_valid(a_valid), .a_data(a_data), .b_valid(b_valid), .b_data(b_data),
    .in_ready(s_in_ready), .res_valid(s_res_valid), .res_match(s_res_match),
    .res_eq(s_res_eq), .res_lt(s_res_lt), .res_gt(s_res_gt), .busy(s_busy),
    .done(s_done), .pass(s_pass), .mismatch_cnt(s_mismatch_cnt), .first_mm_idx(s_first_mm_idx)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass = 0;
  int   n_res = 0;
  int   cyc = 0;
  exp_t sb_q[$];

  int   m_mode, m_cnt, m_first, m_idx;
  int   pa[$], pb[$], st[$];
  int   ign_at = -1;
  int   ign_len = 0;
  bit   chk_sat = 1'b0;
  int   d_cnt, d_first, d_pass;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic bit ref_match(input int md, input int a, input int b);
    case (md)
      0:       return a == b;
      1:       return a != b;
      2:       return a < b;
      default: return a > b;
    endcase
  endfunction

  // Monitor: every result pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && res_valid) begin
      n_res++;
      if (sb_q.size() == 0) begin
        chk("unexpected_res_valid", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("res_match", res_match, e.match);
        chk("res_eq", res_eq, e.eq);
        chk("res_lt", res_lt, e.lt);
        chk("res_gt", res_gt, e.gt);
        chk("mismatch_cnt", mismatch_cnt, e.cnt);
        if (e.cnt != 0) chk("first_mm_idx", first_mm_idx, e.first);
      end
    end
  end

  task automatic issue_pair(input int a, input int b);
    exp_t e;
    bit   mt;
    chk("in_ready_run", in_ready, 1);
    a_valid = 1'b1; b_valid = 1'b1;
    a_data = 4'(a); b_data = 4'(b);
    mt = ref_match(m_mode, a, b);
    if (!mt) begin
      if (m_cnt == 0) m_first = m_idx;
      if (m_cnt < 255) m_cnt++;
    end
    m_idx++;
    e.match = mt; e.eq = (a == b); e.lt = (a < b); e.gt = (a > b);
    e.cnt = m_cnt; e.first = m_first;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  // One complete run using pa/pb/st; entered and left just after a negedge.
  task automatic run_test(input int md, input int ln);
    int t0, stalls, nres0;
    stalls = 0;
    nres0 = n_res;
    m_mode = md; m_cnt = 0; m_first = 0; m_idx = 0;
    start = 1'b1; mode = 2'(md); len = 9'(ln);
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    mode = 2'($urandom_range(3, 0));
    len = 9'($urandom_range(511, 0));
    if (ln == 0) begin
      chk("zl_done", done, 1);
      chk("zl_pass", pass, 1);
      chk("zl_in_ready", in_ready, 0);
      chk("zl_res_valid", res_valid, 0);
      chk("zl_latency", cyc - t0, 1);
      d_cnt = mismatch_cnt; d_first = first_mm_idx; d_pass = pass;
    end else begin
      for (int i = 0; i < ln; i++) begin
        for (int s = 0; s < st[i]; s++) begin
          chk("in_ready_stall", in_ready, 1);
          a_valid = 1'b1; b_valid = 1'b0;
          a_data = 4'($urandom_range(15, 0));
          @(negedge clk);
          stalls++;
        end
        if (i == ign_at) begin
          start = 1'b1; len = 9'(ign_len);
        end
        issue_pair(pa[i], pb[i]);
        start = 1'b0;
      end
      a_valid = 1'b0; b_valid = 1'b0;
      chk("done_pulse", done, 1);
      chk("done_in_ready", in_ready, 0);
      chk("done_busy", busy, 0);
      chk("done_pass", pass, (m_cnt == 0));
      chk("done_cnt", mismatch_cnt, m_cnt);
      if (m_cnt != 0) chk("done_first", first_mm_idx, m_first);
      chk("done_latency", cyc - t0, ln + stalls + 1);
      if (chk_sat) begin
        chk("sat_done", s_done, 1);
        chk("sat_cnt", s_mismatch_cnt, 3);
        chk("sat_pass", s_pass, 0);
      end
      d_cnt = mismatch_cnt; d_first = first_mm_idx; d_pass = pass;
    end
    #1;
    chk("res_valid_count", n_res - nres0, ln);
    chk("scoreboard_empty", sb_q.size(), 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_in_ready", in_ready, 0);
  endtask

  task automatic clear_lists();
    pa.delete(); pb.delete(); st.delete();
    ign_at = -1; chk_sat = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ln, md, a;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_flags", {res_match, res_eq, res_lt, res_gt}, 0);
    chk("rst_busy_done", {busy, done}, 0);
    chk("rst_pass", pass, 0);
    chk("rst_cnt", mismatch_cnt, 0);
    chk("rst_first", first_mm_idx, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Exhaustive EQ sweep over all 4-bit pairs.
    clear_lists();
    for (int i = 0; i < 256; i++) begin
      pa.push_back(i / 16); pb.push_back(i % 16); st.push_back(0);
    end
    run_test(0, 256);
    chk("sweep_cnt", d_cnt, 240);
    chk("sweep_first", d_first, 1);
    chk("sweep_pass", d_pass, 0);

    // LT with a two-cycle b_valid stall before the second pair.
    clear_lists();
    pa = '{2, 5, 7}; pb = '{5, 2, 7}; st = '{0, 2, 0};
    run_test(2, 3);
    chk("lt_cnt", d_cnt, 2);
    chk("lt_first", d_first, 1);

    // Zero-length run.
    clear_lists();
    run_test(1, 0);

    // Saturation on the 2-bit counter instance.
    clear_lists();
    pa = '{0, 1, 2, 3, 4, 5}; pb = '{9, 8, 7, 6, 15, 14}; st = '{0, 0, 0, 0, 0, 0};
    chk_sat = 1'b1;
    run_test(0, 6);
    chk("sat_main_cnt", d_cnt, 6);

    // Start pulsed mid-run with a different length is ignored.
    clear_lists();
    for (int i = 0; i < 8; i++) begin
      pa.push_back(i); pb.push_back((i % 3 == 0) ? i : 15 - i); st.push_back(0);
    end
    ign_at = 4; ign_len = 2;
    run_test(1, 8);

    // Asynchronous reset after three beats of a run.
    clear_lists();
    m_mode = 0; m_cnt = 0; m_first = 0; m_idx = 0;
    start = 1'b1; mode = 2'd0; len = 9'd10;
    @(negedge clk);
    start = 1'b0;
    issue_pair(1, 2);
    issue_pair(3, 3);
    issue_pair(4, 5);
    #2 rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_res", {res_valid, res_match, res_eq, res_lt, res_gt}, 0);
    chk("mrst_busy_done", {busy, done}, 0);
    chk("mrst_pass", pass, 0);
    chk("mrst_cnt", mismatch_cnt, 0);
    chk("mrst_first", first_mm_idx, 0);
    sb_q.delete();
    @(negedge clk);
    chk("mrst_no_done", done, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {in_ready, done, busy}, 0);
    clear_lists();
    pa = '{6, 6, 0, 9}; pb = '{6, 6, 0, 9}; st = '{0, 1, 0, 0};
    run_test(0, 4);
    chk("post_rst_pass", d_pass, 1);

    // Randomized runs.
    for (int r = 0; r < 12; r++) begin
      clear_lists();
      ln = $urandom_range(20, 1);
      md = $urandom_range(3, 0);
      for (int i = 0; i < ln; i++) begin
        a = $urandom_range(15, 0);
        pa.push_back(a);
        pb.push_back(($urandom_range(3, 0) == 0) ? a : int'($urandom_range(15, 0)));
        st.push_back(($urandom_range(3, 0) == 0) ? int'($urandom_range(2, 1)) : 0);
      end
      run_test(md, ln);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_comparator.md
# stream_comparator

Parametrised, sequential successor to the team's 4-bit combinational equality checker. Compares two WIDTH-bit operand streams word by word under a selectable match mode, with a valid/ready handshake. Keeps a saturating mismatch count and records the index of the first mismatch. Reports a pass/fail verdict after a programmed number of word pairs, so a bench or self-test controller can run a whole truth-table sweep and read back one result.

## Interface
Parameters:
- `WIDTH`, default 4: operand width in bits.
- `LEN_W`, default 8: width of the length register and the index counters.
- `CNT_W`, default 8: width of the mismatch counter. It saturates.

Ports:
- `clk`, in, 1: the single clock. All state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begins a run. Sampled only in IDLE.
- `mode`, in, 2: match mode, latched at `start`. 00 = EQ (a==b), 01 = NE, 10 = LT (a<b, unsigned), 11 = GT (a>b, unsigned).
- `len`, in, LEN_W: number of word pairs in the run. Latched at `start`.
- `a_valid`, in, 1; `a_data`, in, WIDTH: operand A stream.
- `b_valid`, in, 1; `b_data`, in, WIDTH: operand B stream.
- `in_ready`, out, 1: high only in RUN.
- `res_valid`, out, 1: one-cycle pulse, one cycle after each accepted beat.
- `res_match`, out, 1: match result of the last accepted pair under the latched `mode`.
- `res_eq`, `res_lt`, `res_gt`, out, 1 each: raw compare flags of the last accepted pair.
- `busy`, out, 1: high in RUN.
- `done`, out, 1: one-cycle pulse at the end of a run.
- `pass`, out, 1: 1 when the finished run had zero mismatches. Held until the next `start`.
- `mismatch_cnt`, out, CNT_W: number of non-matching pairs in the current or last run.
- `first_mm_idx`, out, LEN_W: index of the first non-matching pair. Valid only when `mismatch_cnt != 0`.

## Operation
- **States:** IDLE, RUN, DONE. Encoding is an enum in the package.
- **IDLE:**
  - `start=1` latches `mode` and `len`, clears `idx`, `mismatch_cnt`, `first_mm_idx` and `pass`.
  - If `len != 0`, go to RUN.
  - If `len == 0`, go directly to DONE with a clean run, so `pass=1`.
- **RUN:**
  - A beat is `a_valid & b_valid & in_ready`. If only one side is valid, nothing is consumed.
  - On a beat:
    - Register the compare flags and `res_match`.
    - If the pair does not match: `mismatch_cnt` increments, saturating at 2^CNT_W−1. If this is the first mismatch of the run, `first_mm_idx` is set to `idx`.
    - `idx` increments.
  - The beat with `idx == len−1` moves the FSM to DONE.
- **DONE:** lasts one cycle. `done=1` and `pass = (mismatch_cnt == 0)`. Then go to IDLE.
- **Start outside IDLE:** `start` in RUN or DONE is ignored. It does not restart the run.
- **Mode and length:** changes on `mode` or `len` after `start` have no effect until the next run.
- **Compare arithmetic:** unsigned, full WIDTH. Exactly one of `res_eq`, `res_lt`, `res_gt` is set on every result.

## Timing
- **Reset values:** every output is 0 and the state is IDLE. This includes `pass`, `mismatch_cnt`, `first_mm_idx` and all `res_*` outputs.
- **Reset mid-run:** clears immediately (asynchronous). No `done` is produced.
- **Start to RUN:** `start` sampled at edge N gives `in_ready=1` from edge N+1.
- **Result latency:** a beat at edge N gives `res_valid`, the `res_*` flags and the updated `mismatch_cnt` visible after edge N.
- **End of run:** the final beat at edge N puts the FSM in DONE after edge N, so `done` is high for one cycle. `in_ready` is 0 during DONE.
- **Final result:** the `res_valid` pulse for the final pair coincides with `done`.
- **Throughput:** one pair per cycle while both inputs are valid. The minimum run time is `len + 2` cycles from `start`.
- **Held values:** `res_*` flags hold their last values between beats; only `res_valid` pulses.

## Structure
- **Package `stream_cmp_pkg`:**
  - `cmp_mode_t` enum: EQ, NE, LT, GT.
  - `cmp_state_t` enum: IDLE, RUN, DONE.
  - A function `mode_match(mode, eq, lt, gt)`.
- **Sub-module `word_compare`:** combinational, WIDTH-parametrised, outputs `eq`/`lt`/`gt`. Instantiated once, between the input ports and the result registers.

## Test plan
- **Exhaustive EQ sweep:** WIDTH=4, `mode`=EQ, `len`=256, A counts 0..15 outer and B 0..15 inner, both always valid → `done` at cycle 258, `mismatch_cnt`=240, `first_mm_idx`=1, `pass`=0.
- **LT with stalls:** `mode`=LT, `len`=3, pairs (2,5), (5,2), (7,7), with `b_valid` dropped for 2 cycles before pair 2 → exactly 3 `res_valid` pulses, `mismatch_cnt`=2, `first_mm_idx`=1.
- **Zero length:** `len`=0 with `start` → `done` after 1 cycle, `pass`=1, no `res_valid`, `in_ready` never high.
- **Saturation:** CNT_W=2, `mode`=EQ, `len`=6, all pairs unequal → `mismatch_cnt`=3, `pass`=0.
- **Ignored start:** `start` pulsed mid-run with a different `len` → the run completes at the original `len` and the counters are not cleared.
- **Reset mid-run:** `rst_n` low after 3 beats → all outputs 0 and state IDLE immediately; the next `start` runs cleanly.
